mux_xor_arbiter: RTL and testbench
==================================

// Module: mux_xor_arbiter
// PURPOSE
//  - Shares one mux-built XOR unit (out = A ? ~B : B, bitwise) among N requesters.
//  - Each requester presents a WIDTH-bit operand pair; a round-robin scheduler grants one at a time.
//  - Operands are captured, run through the shared unit for LAT cycles, and returned with the winner's id.
//  - Sits between the per-channel request logic and the single mux-based XOR datapath.
// PARAMETERS
//  N      4  number of requesters (2..8)
//  WIDTH  8  operand/result width in bits
//  LAT    2  execute cycles in the shared unit (>=1)
//  IDW    2  width of res_id, = ceil(log2(N))
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  req        in   N        request per requester; held high until its gnt bit pulses
//  a_bus      in   N*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//  b_bus      in   N*WIDTH  operand B; same packing as a_bus
//  gnt        out  N        one-hot, one-cycle pulse: requester's operands captured
//  res        out  WIDTH    result A ^ B of granted requester
//  res_id     out  IDW      index of requester owning res
//  res_valid  out  1        res/res_id valid; held until res_ready
//  res_ready  in   1        consumer accepts result
//  busy       out  1        high in EXEC or DONE
// BEHAVIOUR
//  - Reset (rst_n low, takes effect immediately): state=IDLE, rr_ptr=0, gnt=0, res=0,
//    res_id=0, res_valid=0, busy=0, operand regs=0. All outputs registered.
//  - FSM IDLE -> EXEC -> DONE -> IDLE.
//  - IDLE, req!=0 at edge:
//    - winner = first set req bit searching rr_ptr, rr_ptr+1, ... wrapping mod N;
//    - capture a_bus/b_bus slice of winner, id=winner;
//    - gnt[winner]=1 for exactly the next cycle;
//    - cnt=LAT-1; go EXEC.
//  - IDLE, req==0: stay; gnt=0.
//  - EXEC: shared unit computes A ? ~B : B per bit (== A^B).
//    - cnt decrements each cycle; at cnt==0 edge load res, res_id; res_valid=1; go DONE.
//    - Grant to result valid = LAT cycles.
//  - DONE: res/res_id/res_valid held stable while res_ready=0.
//    - On edge with res_ready=1: res_valid=0, rr_ptr=(id+1) mod N, go IDLE.
//    - res keeps last value after handoff.
//  - req changes outside IDLE are ignored; requests are not queued.
//    - A req dropped before its gnt is withdrawn without error.
//  - Min issue interval LAT+2 cycles (IDLE, LAT x EXEC, DONE with res_ready=1).
//  - Wrap: rr_ptr after serving N-1 returns to 0; with all req high, grant order 0,1,..,N-1,0.
//  - Bits of req at index >= N do not exist; res_id never >= N.
//  - Reset mid-EXEC/DONE: operation discarded, no res_valid, rr_ptr back to 0.
// CONFIGURATION
//  - MUX_XOR_ARB_STATS_EN defined:
//    - adds output op_count (8 bits): count of completed handoffs (DONE & res_ready);
//    - saturates at 8'hFF; reset to 0.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset, req=4'b0001, a0=8'hF0, b0=8'h3C, LAT=2:
//    gnt=4'b0001 one cycle; res_valid 2 cycles later; res=8'hCC, res_id=0.
//  - req=4'b1111 held, res_ready=1 always -> grants in order 0,1,2,3,0; issue every 4 cycles.
//  - DONE with res_ready=0 for 5 cycles -> res/res_id/res_valid stable.
//    - No new gnt despite req=4'b0010; gnt[1] after ready.
//  - rr_ptr=3 (after serving 2), req=4'b0101 -> requester 0 granted (wrap), then 2.
//  - rst_n low mid-EXEC -> outputs zero immediately; after release, req=4'b0100 granted first.
//  - STATS_EN: 260 completed ops -> op_count=8'hFF; without macro, build has no op_count port.

Source files
------------

// File: rtl/mux_xor_arbiter.sv
// ---------------------------------------------------------------------------
// mux_xor_arbiter
//
// Purpose:
//    Shares a single mux-built XOR unit (out = A ? ~B : B, bitwise) among N
//    requesters. A round-robin scheduler picks one requester at a time and
//    captures its operand pair. The pair is run through the shared unit for
//    LAT cycles, and the result is returned tagged with the winner's index.
//    The result is held until the consumer accepts it.
//
// Ports:
//    clk          in   1          rising-edge clock
//    rst_n        in   1          asynchronous, active-low reset
//    i_req        in   N          request per requester, held until its grant
//    i_a_bus      in   N*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//    i_b_bus      in   N*WIDTH    operand B, same packing as i_a_bus
//    o_gnt        out  N          one-hot, one-cycle pulse on operand capture
//    o_res        out  WIDTH      A ^ B of the granted requester
//    o_res_id     out  IDW        index of the requester owning o_res
//    o_res_valid  out  1          o_res/o_res_id valid, held until accepted
//    i_res_ready  in   1          consumer accepts the result
//    o_busy       out  1          high while an operation is in flight
//    o_op_count   out  8          completed handoffs, saturating
//                                 (only when MUX_XOR_ARB_STATS_EN is defined)
//
// Configuration macro:
//    MUX_XOR_ARB_STATS_EN - adds the o_op_count port and its counter.
// ---------------------------------------------------------------------------
module mux_xor_arbiter #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int LAT   = 2,
   parameter int IDW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         i_req,
   input  logic [N*WIDTH-1:0]   i_a_bus,
   input  logic [N*WIDTH-1:0]   i_b_bus,
   output logic [N-1:0]         o_gnt,
   output logic [WIDTH-1:0]     o_res,
   output logic [IDW-1:0]       o_res_id,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic                 o_busy
`ifdef MUX_XOR_ARB_STATS_EN
   ,
   output logic [7:0]           o_op_count
`endif
);

   localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [IDW-1:0]       r_rrPtr;
   logic [IDW-1:0]       r_id;
   logic [CNTW-1:0]      r_cnt;
   logic [WIDTH-1:0]     r_opA;
   logic [WIDTH-1:0]     r_opB;
   logic [N-1:0]         r_gnt;
   logic [WIDTH-1:0]     r_res;
   logic [IDW-1:0]       r_resId;
   logic                 r_resValid;
   logic                 r_busy;

   logic                 w_found;
   logic [IDW-1:0]       w_winner;
   logic [IDW-1:0]       w_cand;
   logic [WIDTH-1:0]     w_xor;
   logic [IDW-1:0]       w_nextPtr;

   // Round-robin search: walk from rr_ptr upward, wrapping modulo N. The loop
   // runs from the farthest candidate back to rr_ptr itself so that the last
   // hit written is the closest one to the pointer, which is the winner.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = IDW'((int'(r_rrPtr) + k) % N);
         if (i_req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // The shared datapath: each output bit is a 2:1 mux selecting ~B or B by
   // A, which is functionally A ^ B built without an XOR gate.
   always_comb begin
      w_xor = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_xor[i] = r_opA[i] ? ~r_opB[i] : r_opB[i];
      end
   end

   // After a handoff, the pointer moves one past the requester just served,
   // wrapping back to zero after the last requester.
   always_comb begin
      w_nextPtr = (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;
   end

   // Main sequencer. IDLE grants and captures the operands. EXEC counts down
   // the latency of the shared unit and loads the result when the count runs
   // out. DONE holds the result until the consumer takes it. The grant is
   // cleared on every edge except the capturing one, so it is a single-cycle
   // pulse. Requests seen outside IDLE are simply ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rrPtr    <= '0;
         r_id       <= '0;
         r_cnt      <= '0;
         r_opA      <= '0;
         r_opB      <= '0;
         r_gnt      <= '0;
         r_res      <= '0;
         r_resId    <= '0;
         r_resValid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_gnt <= '0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt    <= N'(1) << w_winner;
                  r_opA    <= i_a_bus[w_winner*WIDTH +: WIDTH];
                  r_opB    <= i_b_bus[w_winner*WIDTH +: WIDTH];
                  r_id     <= w_winner;
                  r_cnt    <= CNTW'(LAT - 1);
                  r_busy   <= 1'b1;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               if (r_cnt == '0) begin
                  r_res      <= w_xor;
                  r_resId    <= r_id;
                  r_resValid <= 1'b1;
                  r_state    <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               if (i_res_ready) begin
                  r_resValid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_rrPtr    <= w_nextPtr;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_res       = r_res;
   assign o_res_id    = r_resId;
   assign o_res_valid = r_resValid;
   assign o_busy      = r_busy;

`ifdef MUX_XOR_ARB_STATS_EN
   logic [7:0] r_opCount;

   // Counts accepted results and sticks at 8'hFF instead of wrapping, so a
   // reader can tell "many" apart from a small count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opCount <= '0;
      end else if ((r_state == DONE) && i_res_ready && (r_opCount != 8'hFF)) begin
         r_opCount <= r_opCount + 8'd1;
      end
   end

   assign o_op_count = r_opCount;
`endif

endmodule

// File: tb/tb_mux_xor_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_xor_arbiter
//
// Purpose:
//    Self-checking bench for mux_xor_arbiter. A transaction-level model tracks
//    which requester owns the shared unit, when its result is due and when it
//    is handed off. A compare process checks every cycle against that model.
//    Directed sequences with hand-computed values pin the model down, and a
//    randomized phase follows them.
//
// Configuration macro:
//    MUX_XOR_ARB_STATS_EN - also exercises and checks o_op_count.
// ---------------------------------------------------------------------------
module tb_mux_xor_arbiter;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int LAT   = 2;
   localparam int IDW   = 2;

   logic                 clk;
   logic                 rst_n;
   logic [N-1:0]         req;
   logic [N*WIDTH-1:0]   aBus;
   logic [N*WIDTH-1:0]   bBus;
   logic [N-1:0]         gnt;
   logic [WIDTH-1:0]     res;
   logic [IDW-1:0]       resId;
   logic                 resValid;
   logic                 resReady;
   logic                 busy;
`ifdef MUX_XOR_ARB_STATS_EN
   logic [7:0]           opCount;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state, kept at transaction level with cycle timestamps.
   int                   mCyc;
   int                   mGrantCyc;
   bit                   mInFlight;
   bit                   mValid;
   int                   mOwner;
   int                   mRr;
   logic [WIDTH-1:0]     mPendRes;
   logic [WIDTH-1:0]     mRes;
   int                   mResId;
   logic [N-1:0]         mGnt;
   int                   mOpCount;

   mux_xor_arbiter #(
      .N     (N),
      .WIDTH (WIDTH),
      .LAT   (LAT),
      .IDW   (IDW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req),
      .i_a_bus     (aBus),
      .i_b_bus     (bBus),
      .o_gnt       (gnt),
      .o_res       (res),
      .o_res_id    (resId),
      .o_res_valid (resValid),
      .i_res_ready (resReady),
      .o_busy      (busy)
`ifdef MUX_XOR_ARB_STATS_EN
      ,
      .o_op_count  (opCount)
`endif
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed and
   // directed checks are made.
   task automatic applyStimulus();
      @(posedge clk);
      #2;
   endtask

   // Reference model. It works from the rules, not the RTL structure: a free
   // requester is chosen by scanning from the round-robin pointer, its result
   // (plain XOR) becomes visible LAT edges after the grant edge, and an
   // accepted result frees the unit and moves the pointer past the owner.
   initial begin
      mCyc = 0; mGrantCyc = 0; mInFlight = 0; mValid = 0; mOwner = 0; mRr = 0;
      mPendRes = '0; mRes = '0; mResId = 0; mGnt = '0; mOpCount = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mInFlight = 0; mValid = 0; mOwner = 0; mRr = 0;
            mRes = '0; mResId = 0; mGnt = '0; mOpCount = 0;
         end else begin
            mCyc++;
            mGnt = '0;
            if (mInFlight && mValid) begin
               if (resReady) begin
                  mValid    = 0;
                  mInFlight = 0;
                  mRr       = (mOwner + 1) % N;
                  if (mOpCount < 255) mOpCount++;
               end
            end else if (mInFlight) begin
               if (mCyc == mGrantCyc + LAT) begin
                  mValid = 1;
                  mRes   = mPendRes;
                  mResId = mOwner;
               end
            end else if (req != '0) begin
               for (int k = 0; k < N; k++) begin
                  if (!mInFlight && req[(mRr + k) % N]) begin
                     mOwner    = (mRr + k) % N;
                     mInFlight = 1;
                  end
               end
               mGrantCyc = mCyc;
               mGnt[mOwner] = 1'b1;
               mPendRes = aBus[mOwner*WIDTH +: WIDTH] ^ bBus[mOwner*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Per-cycle comparison against the model, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            checkOutput("gnt", 32'(gnt), 32'(mGnt));
            checkOutput("busy", 32'(busy), 32'(mInFlight));
            checkOutput("res_valid", 32'(resValid), 32'(mValid));
            checkOutput("res", 32'(res), 32'(mRes));
            checkOutput("res_id", 32'(resId), 32'(mResId));
`ifdef MUX_XOR_ARB_STATS_EN
            checkOutput("op_count", 32'(opCount), 32'(mOpCount));
`endif
         end
      end
   end

   // Directed sequences with hand-computed values, then randomized traffic.
   initial begin
      rst_n    = 1'b0;
      req      = '0;
      resReady = 1'b0;
      aBus     = 32'hF0F0_F0F0;
      bBus     = 32'h3C3C_3C3C;
      #1;
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_valid", 32'(resValid), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_res", 32'(res), 32'h0);
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;

      // Single request from requester 0: F0 ^ 3C = CC after LAT cycles.
      req = 4'b0001;
      applyStimulus();
      checkOutput("t1_gnt", 32'(gnt), 32'h1);
      checkOutput("t1_busy", 32'(busy), 32'h1);
      req = 4'b0000;
      applyStimulus();
      checkOutput("t1_gnt_pulse", 32'(gnt), 32'h0);
      checkOutput("t1_not_valid", 32'(resValid), 32'h0);
      applyStimulus();
      checkOutput("t1_valid", 32'(resValid), 32'h1);
      checkOutput("t1_res", 32'(res), 32'hCC);
      checkOutput("t1_res_id", 32'(resId), 32'h0);

      // Stall in DONE with a pending request: nothing moves until ready.
      req = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("stall_valid", 32'(resValid), 32'h1);
         checkOutput("stall_res", 32'(res), 32'hCC);
         checkOutput("stall_id", 32'(resId), 32'h0);
         checkOutput("stall_gnt", 32'(gnt), 32'h0);
      end
      resReady = 1'b1;
      applyStimulus();
      checkOutput("handoff_valid", 32'(resValid), 32'h0);
      checkOutput("handoff_res_kept", 32'(res), 32'hCC);
      applyStimulus();
      checkOutput("after_ready_gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      repeat (3) applyStimulus();

      // Serve requester 2 so the pointer sits at 3, then 0 and 2 compete.
      req = 4'b0100;
      applyStimulus();
      checkOutput("serve2_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      repeat (3) applyStimulus();
      req = 4'b0101;
      applyStimulus();
      checkOutput("wrap_gnt0", 32'(gnt), 32'h1);
      req = 4'b0100;
      repeat (3) applyStimulus();
      applyStimulus();
      checkOutput("wrap_gnt2", 32'(gnt), 32'h4);
      req = 4'b0000;
      repeat (3) applyStimulus();

      // Reset in the middle of EXEC clears everything at once.
      req = 4'b0010;
      applyStimulus();
      checkOutput("pre_reset_gnt", 32'(gnt), 32'h2);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_gnt", 32'(gnt), 32'h0);
      checkOutput("midreset_busy", 32'(busy), 32'h0);
      checkOutput("midreset_valid", 32'(resValid), 32'h0);
      checkOutput("midreset_res", 32'(res), 32'h0);
      req = 4'b0000;
      applyStimulus();
      rst_n = 1'b1;
      req = 4'b0100;
      applyStimulus();
      checkOutput("post_reset_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      repeat (3) applyStimulus();

      // All requesters busy from a fresh pointer: 0,1,2,3,0 every LAT+2.
      rst_n = 1'b0;
      applyStimulus();
      rst_n = 1'b1;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         checkOutput("rr_gnt", 32'(gnt), 32'(1) << (k % N));
         if (k < 4) begin
            for (int j = 0; j < LAT + 1; j++) begin
               applyStimulus();
               checkOutput("rr_gap", 32'(gnt), 32'h0);
            end
         end
      end
      req = 4'b0000;
      repeat (3) applyStimulus();

`ifdef MUX_XOR_ARB_STATS_EN
      // Saturation of the handoff counter after more than 255 operations.
      rst_n = 1'b0;
      applyStimulus();
      rst_n = 1'b1;
      checkOutput("stats_reset", 32'(opCount), 32'h0);
      req = 4'b0001;
      resReady = 1'b1;
      repeat (260 * (LAT + 2)) applyStimulus();
      checkOutput("stats_saturate", 32'(opCount), 32'hFF);
      req = 4'b0000;
      repeat (4) applyStimulus();
`endif

      // Randomized traffic with occasional back-pressure and resets.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus();
         req      = N'($urandom_range(0, (1 << N) - 1));
         aBus     = $urandom;
         bBus     = $urandom;
         resReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            applyStimulus();
            rst_n = 1'b1;
         end
      end
      applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
